// File: rtl/pwm_car_motor_core.sv
// PWM / H-bridge drive core: prescaled period counter, double-buffered config,
// per-motor duty compare and dead-time-protected direction control.
module pwm_car_motor_core #(
    parameter int CNT_W    = 16,
    parameter int PRESC_W  = 8,
    parameter int DEADTIME = 16
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_enable,
    input  logic [1:0]         cfg_dir,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_duty_l,
    input  logic [CNT_W-1:0]   cfg_duty_r,
    output logic [1:0]         pwm_en,
    output logic [1:0]         in_l,
    output logic [1:0]         in_r,
    output logic               period_tick,
    output logic               update_pending
);

    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    typedef enum logic {ST_RUN, ST_DEAD} dir_state_t;

    logic [1:0]         pend_enable_reg, pend_dir_reg;
    logic [PRESC_W-1:0] pend_presc_reg;
    logic [CNT_W-1:0]   pend_period_reg, pend_duty_l_reg, pend_duty_r_reg;
    logic               update_pending_reg;

    logic [1:0]         act_enable_reg, act_dir_reg;
    logic [PRESC_W-1:0] act_presc_reg;
    logic [CNT_W-1:0]   act_period_reg, act_duty_l_reg, act_duty_r_reg;

    logic [PRESC_W-1:0] presc_cnt_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               period_tick_reg;

    logic               tick, wrap;
    logic [CNT_W-1:0]   act_duty [2];
    logic [1:0]         ch_in [2];

    assign tick        = (presc_cnt_reg == act_presc_reg);
    assign wrap        = tick && (cnt_reg == act_period_reg);
    assign act_duty[0] = act_duty_l_reg;
    assign act_duty[1] = act_duty_r_reg;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            presc_cnt_reg   <= '0;
            cnt_reg         <= '0;
            period_tick_reg <= 1'b0;
        end else begin
            period_tick_reg <= wrap;
            presc_cnt_reg   <= tick ? '0 : presc_cnt_reg + 1'b1;
            if (tick) begin
                cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    // Active set only moves on a wrap, so every period runs on one consistent config.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pend_enable_reg    <= '0;
            pend_dir_reg       <= '0;
            pend_presc_reg     <= '0;
            pend_period_reg    <= '0;
            pend_duty_l_reg    <= '0;
            pend_duty_r_reg    <= '0;
            update_pending_reg <= 1'b0;
            act_enable_reg     <= '0;
            act_dir_reg        <= 2'b11;
            act_presc_reg      <= '0;
            act_period_reg     <= '0;
            act_duty_l_reg     <= '0;
            act_duty_r_reg     <= '0;
        end else begin
            if (wrap && update_pending_reg) begin
                act_enable_reg <= pend_enable_reg;
                act_dir_reg    <= pend_dir_reg;
                act_presc_reg  <= pend_presc_reg;
                act_period_reg <= pend_period_reg;
                act_duty_l_reg <= pend_duty_l_reg;
                act_duty_r_reg <= pend_duty_r_reg;
            end
            if (cfg_wr) begin
                pend_enable_reg    <= cfg_enable;
                pend_dir_reg       <= cfg_dir;
                pend_presc_reg     <= cfg_presc;
                pend_period_reg    <= cfg_period;
                pend_duty_l_reg    <= cfg_duty_l;
                pend_duty_r_reg    <= cfg_duty_r;
                update_pending_reg <= 1'b1;
            end else if (wrap) begin
                update_pending_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            dir_state_t        state_reg;
            logic [DEAD_W-1:0] dead_cnt_reg;
            logic              drv_dir_reg, dead_dir_reg;
            logic              en_reg;
            logic [1:0]        in_reg;
            logic              raw;

            assign raw = act_enable_reg[gi] && (cnt_reg < act_duty[gi]);

            always_ff @(posedge ACLK) begin
                if (ARESET) begin
                    state_reg    <= ST_RUN;
                    dead_cnt_reg <= '0;
                    drv_dir_reg  <= 1'b1;
                    dead_dir_reg <= 1'b1;
                    en_reg       <= 1'b0;
                    in_reg       <= 2'b00;
                end else begin
                    case (state_reg)
                        ST_RUN: begin
                            if (act_dir_reg[gi] != drv_dir_reg) begin
                                state_reg    <= ST_DEAD;
                                dead_cnt_reg <= '0;
                                dead_dir_reg <= act_dir_reg[gi];
                                en_reg       <= 1'b0;
                                in_reg       <= 2'b00;
                            end else begin
                                en_reg <= raw;
                                in_reg <= act_enable_reg[gi] ? (drv_dir_reg ? 2'b10 : 2'b01) : 2'b00;
                            end
                        end
                        ST_DEAD: begin
                            if (act_dir_reg[gi] != dead_dir_reg) begin
                                dead_cnt_reg <= '0;
                                dead_dir_reg <= act_dir_reg[gi];
                                en_reg       <= 1'b0;
                                in_reg       <= 2'b00;
                            end else if (dead_cnt_reg == DEAD_LAST) begin
                                // Resume on the completing cycle so the low window is exactly DEADTIME long.
                                state_reg   <= ST_RUN;
                                drv_dir_reg <= act_dir_reg[gi];
                                en_reg      <= raw;
                                in_reg      <= act_enable_reg[gi] ? (act_dir_reg[gi] ? 2'b10 : 2'b01) : 2'b00;
                            end else begin
                                dead_cnt_reg <= dead_cnt_reg + 1'b1;
                                en_reg       <= 1'b0;
                                in_reg       <= 2'b00;
                            end
                        end
                        default: state_reg <= ST_RUN;
                    endcase
                end
            end

            assign pwm_en[gi] = en_reg;
            assign ch_in[gi]  = in_reg;
        end
    endgenerate

    assign in_l           = ch_in[0];
    assign in_r           = ch_in[1];
    assign period_tick    = period_tick_reg;
    assign update_pending = update_pending_reg;

endmodule

// File: tb/tb_pwm_car_motor_core.sv
// Self-checking bench: directed scenarios plus randomized config traffic,
// compared every cycle against a behavioural model of the drive core.
module tb_pwm_car_motor_core;

    localparam int CNT_W    = 16;
    localparam int PRESC_W  = 8;
    localparam int DEADTIME = 16;

    logic               tb_ACLK, tb_ARESET, cfg_wr;
    logic [1:0]         cfg_enable, cfg_dir;
    logic [PRESC_W-1:0] cfg_presc;
    logic [CNT_W-1:0]   cfg_period, cfg_duty_l, cfg_duty_r;
    logic [1:0]         pwm_en, in_l, in_r;
    logic               period_tick, update_pending;

    pwm_car_motor_core #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .DEADTIME(DEADTIME)) dut (
        .ACLK(tb_ACLK), .ARESET(tb_ARESET), .cfg_wr(cfg_wr),
        .cfg_enable(cfg_enable), .cfg_dir(cfg_dir), .cfg_presc(cfg_presc),
        .cfg_period(cfg_period), .cfg_duty_l(cfg_duty_l), .cfg_duty_r(cfg_duty_r),
        .pwm_en(pwm_en), .in_l(in_l), .in_r(in_r),
        .period_tick(period_tick), .update_pending(update_pending)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    int vectors = 0;
    int errors  = 0;
    bit checking = 0;

    // ---------------- behavioural model ----------------
    int m_pc, m_cnt, m_upd;
    int a_presc, a_period, a_duty[2], a_en[2], a_dir[2];
    int p_presc, p_period, p_duty[2], p_en[2], p_dir[2];
    int drv[2], tgt[2], mdead[2];
    int raw, o_en;
    logic [1:0] o_in;
    bit m_tick, m_wrap;
    logic [1:0] exp_pwm;
    logic [1:0] exp_in [2];
    logic exp_pt, exp_upd;

    function automatic logic [1:0] bridge(input int en, input int dir);
        if (en == 0) return 2'b00;
        return (dir != 0) ? 2'b10 : 2'b01;
    endfunction

    always @(posedge tb_ACLK) begin
        if (tb_ARESET) begin
            m_pc = 0; m_cnt = 0; m_upd = 0;
            a_presc = 0; a_period = 0; p_presc = 0; p_period = 0;
            for (int ch = 0; ch < 2; ch++) begin
                a_duty[ch] = 0; a_en[ch] = 0; a_dir[ch] = 1;
                p_duty[ch] = 0; p_en[ch] = 0; p_dir[ch] = 0;
                drv[ch] = 1; tgt[ch] = 1; mdead[ch] = 0;
                exp_in[ch] = 2'b00;
            end
            exp_pwm = 2'b00; exp_pt = 0; exp_upd = 0;
        end else begin
            m_tick = (m_pc == a_presc);
            m_wrap = m_tick && (m_cnt == a_period);
            for (int ch = 0; ch < 2; ch++) begin
                raw  = (a_en[ch] != 0 && m_cnt < a_duty[ch]) ? 1 : 0;
                o_en = 0; o_in = 2'b00;
                if (mdead[ch] == 0 && a_dir[ch] == drv[ch]) begin
                    o_en = raw; o_in = bridge(a_en[ch], drv[ch]);
                end else if (mdead[ch] == 0) begin
                    mdead[ch] = DEADTIME; tgt[ch] = a_dir[ch];
                end else if (a_dir[ch] != tgt[ch]) begin
                    mdead[ch] = DEADTIME; tgt[ch] = a_dir[ch];
                end else if (mdead[ch] == 1) begin
                    mdead[ch] = 0; drv[ch] = a_dir[ch];
                    o_en = raw; o_in = bridge(a_en[ch], drv[ch]);
                end else begin
                    mdead[ch]--;
                end
                exp_pwm[ch] = o_en[0];
                exp_in[ch]  = o_in;
            end
            exp_pt = m_wrap;
            m_pc = m_tick ? 0 : m_pc + 1;
            if (m_tick) m_cnt = m_wrap ? 0 : m_cnt + 1;
            if (m_wrap && m_upd != 0) begin
                a_presc = p_presc; a_period = p_period;
                for (int ch = 0; ch < 2; ch++) begin
                    a_duty[ch] = p_duty[ch]; a_en[ch] = p_en[ch]; a_dir[ch] = p_dir[ch];
                end
                m_upd = 0;
            end
            if (cfg_wr) begin
                p_presc = cfg_presc; p_period = cfg_period;
                p_duty[0] = cfg_duty_l; p_duty[1] = cfg_duty_r;
                for (int ch = 0; ch < 2; ch++) begin
                    p_en[ch] = cfg_enable[ch]; p_dir[ch] = cfg_dir[ch];
                end
                m_upd = 1;
            end
            exp_upd = (m_upd != 0);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge tb_ACLK) begin
        if (checking) begin
            vectors++;
            if (pwm_en !== exp_pwm || in_l !== exp_in[0] || in_r !== exp_in[1] ||
                period_tick !== exp_pt || update_pending !== exp_upd) begin
                errors++;
                if (errors < 30)
                    $display("FAIL model t=%0t got pwm=%b l=%b r=%b pt=%b up=%b expected pwm=%b l=%b r=%b pt=%b up=%b",
                             $time, pwm_en, in_l, in_r, period_tick, update_pending,
                             exp_pwm, exp_in[0], exp_in[1], exp_pt, exp_upd);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg(input int presc, input int period, input int dl, input int dr,
                       input int en, input int dir);
        @(negedge tb_ACLK);
        cfg_presc  = PRESC_W'(presc);
        cfg_period = CNT_W'(period);
        cfg_duty_l = CNT_W'(dl);
        cfg_duty_r = CNT_W'(dr);
        cfg_enable = 2'(en);
        cfg_dir    = 2'(dir);
        cfg_wr     = 1'b1;
        @(negedge tb_ACLK);
        cfg_wr     = 1'b0;
    endtask

    // Samples up to and including the next period_tick; returns length and high counts.
    task automatic wait_tick(output int n, output int hl, output int hr);
        n = 0; hl = 0; hr = 0;
        do begin
            @(negedge tb_ACLK);
            n++;
            hl += int'(pwm_en[0]);
            hr += int'(pwm_en[1]);
        end while (!period_tick && n < 200);
        if (n >= 200) begin
            vectors++; errors++;
            $display("FAIL tick_timeout: got no period_tick in %0d cycles expected one", n);
        end
    endtask

    int n, hl, hr, zeros, k;
    bit right_ok;

    initial begin
        tb_ARESET = 1'b1; cfg_wr = 1'b0;
        cfg_enable = '0; cfg_dir = '0; cfg_presc = '0;
        cfg_period = '0; cfg_duty_l = '0; cfg_duty_r = '0;
        @(negedge tb_ACLK);
        checking = 1;
        repeat (4) @(negedge tb_ACLK);
        check("reset_outputs", {pwm_en, in_l, in_r, period_tick, update_pending}, 0);
        tb_ARESET = 1'b0;
        repeat (5) @(negedge tb_ACLK);
        check("idle_outputs", {pwm_en, in_l, in_r, update_pending}, 0);

        // Basic PWM
        cfg(0, 9, 3, 10, 3, 3);
        wait_tick(n, hl, hr); wait_tick(n, hl, hr); wait_tick(n, hl, hr);
        check("basic_period", n, 10);
        check("basic_high_l", hl, 3);
        check("basic_high_r", hr, 10);
        check("basic_in_l", in_l, 2);
        check("basic_in_r", in_r, 2);

        // Mid-period update of duty_l
        repeat (3) @(negedge tb_ACLK);
        cfg(0, 9, 7, 10, 3, 3);
        check("mid_pending_set", update_pending, 1);
        wait_tick(n, hl, hr);
        check("mid_pending_clear", update_pending, 0);
        wait_tick(n, hl, hr);
        check("mid_high_l", hl, 7);

        // Coincident write: queued 2, then 5 written on the wrap cycle
        repeat (2) @(negedge tb_ACLK);
        cfg(0, 9, 2, 10, 3, 3);
        repeat (4) @(negedge tb_ACLK);
        cfg(0, 9, 5, 10, 3, 3);
        check("coinc_on_wrap", period_tick, 1);
        check("coinc_pending_kept", update_pending, 1);
        wait_tick(n, hl, hr);
        check("coinc_high_first", hl, 2);
        check("coinc_pending_clear", update_pending, 0);
        wait_tick(n, hl, hr);
        check("coinc_high_second", hl, 5);

        // Left reversal
        cfg(0, 9, 5, 10, 3, 2);
        k = 0;
        while (in_l != 2'b00 && k < 50) begin @(negedge tb_ACLK); k++; end
        zeros = 0; right_ok = 1;
        while (in_l == 2'b00 && zeros < 100) begin
            if (in_r != 2'b10 || pwm_en[0]) right_ok = 0;
            @(negedge tb_ACLK); zeros++;
        end
        check("rev_dead_len", zeros, DEADTIME);
        check("rev_in_l", in_l, 1);
        check("rev_right_and_en", int'(right_ok), 1);

        // Prescale
        cfg(3, 4, 2, 3, 3, 2);
        wait_tick(n, hl, hr); wait_tick(n, hl, hr); wait_tick(n, hl, hr);
        check("presc_period", n, 20);
        check("presc_high_l", hl, 8);
        check("presc_high_r", hr, 12);

        // Abort mid-period with a pending config
        repeat (7) @(negedge tb_ACLK);
        cfg(0, 3, 1, 1, 3, 1);
        tb_ARESET = 1'b1;
        @(negedge tb_ACLK);
        check("abort_outputs", {pwm_en, in_l, in_r, period_tick, update_pending}, 0);
        tb_ARESET = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge tb_ACLK);
            cfg_presc  = PRESC_W'($urandom_range(0, 3));
            cfg_period = CNT_W'($urandom_range(0, 15));
            cfg_duty_l = CNT_W'($urandom_range(0, 17));
            cfg_duty_r = CNT_W'($urandom_range(0, 17));
            cfg_enable = 2'($urandom_range(0, 3));
            cfg_dir    = 2'($urandom_range(0, 3));
            cfg_wr     = ($urandom_range(0, 29) == 0);
            tb_ARESET  = ($urandom_range(0, 699) == 0);
        end
        @(negedge tb_ACLK);
        cfg_wr = 1'b0; tb_ARESET = 1'b0;
        repeat (5) @(negedge tb_ACLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pwm_car_motor_core.md
Name: pwm_car_motor_core

Overview:
- Downstream PWM/H-bridge drive core behind the PWM_car AXI4-Lite register slave.
- Consumes the slave's register fields (enable, direction, prescale, period, per-motor duty) plus a write strobe.
- Generates glitch-free, period-aligned PWM for the left and right motors.
- Outputs EN/IN1/IN2 per motor, with dead-time insertion on every direction reversal.

Parameters:
CNT_W, 16, width of period/duty counter and compare values
PRESC_W, 8, width of clock prescaler
DEADTIME, 16, ACLK cycles both bridge inputs are held low on a direction change

Ports:
ACLK  in  1  system clock, all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cfg_wr  in  1  one-cycle strobe: capture all cfg_* inputs into pending set
cfg_enable  in  2  per-motor enable, bit0=left, bit1=right
cfg_dir  in  2  per-motor direction, 1=forward, 0=reverse, bit0=left
cfg_presc  in  PRESC_W  counter ticks every cfg_presc+1 ACLK cycles
cfg_period  in  CNT_W  counter runs 0..cfg_period (period = cfg_period+1 ticks)
cfg_duty_l  in  CNT_W  left high-time in ticks
cfg_duty_r  in  CNT_W  right high-time in ticks
pwm_en  out  2  bridge enable (ENA/ENB), bit0=left
in_l  out  2  left bridge {IN1,IN2}
in_r  out  2  right bridge {IN1,IN2}
period_tick  out  1  one-cycle pulse at each period wrap
update_pending  out  1  pending config not yet applied

Behaviour:
- Reset (ARESET=1 at rising edge):
  - all outputs 0; pending regs 0; update_pending 0.
  - active presc/period/duty/enable 0; active dir and driven dir 2'b11.
  - prescaler and period counters 0; both direction FSMs in RUN.
- Prescaler:
  - presc_cnt increments each cycle; tick=1 when presc_cnt==active presc, then presc_cnt wraps to 0.
  - presc=0 gives a tick every cycle.
- Period counter:
  - On tick, cnt increments; wrap = tick && cnt==active period, then cnt goes to 0.
  - period=0 wraps on every tick.
  - period_tick is registered: high the cycle after a wrap, for exactly one cycle.
- Config double-buffering:
  - cfg_wr copies all cfg_* inputs into pending and sets update_pending.
  - On wrap with update_pending=1: pending is copied to active and update_pending is cleared.
  - cfg_wr on the same cycle as wrap: the old pending applies; the new values land in pending and update_pending stays 1.
  - Back-to-back cfg_wr: last write wins.
  - Active values never change mid-period, so there are no runt pulses.
- Compare (per motor):
  - raw = active enable[ch] && (cnt < active duty[ch]).
  - duty=0 gives always 0; duty > period gives 100%.
  - Unsigned compare, CNT_W bits, no overflow paths.
- Direction FSM (per motor), states RUN and DEAD:
  - RUN:
    - enabled channel: in = driven dir ? 2'b10 : 2'b01, and pwm_en = raw, registered.
    - disabled channel: in=2'b00 (coast), pwm_en=0.
  - RUN -> DEAD when active dir != driven dir.
  - DEAD: pwm_en=0, in=2'b00, dead counter counts DEADTIME ACLK cycles.
  - DEAD -> RUN when the count completes; driven dir <= active dir at that moment.
  - Active dir changing again while in DEAD restarts the count.
  - Dead-time applies even when the channel is disabled; the outputs are identical, so it is invisible.
- Latency:
  - pwm_en/in_* are registered, 1 ACLK after the cnt value that produced them.
  - A config becomes visible 1 cycle after the wrap that applies it.
- From reset: active period=0 and presc=0 wrap every cycle, so the first cfg_wr applies on the next cycle.
- ARESET mid-period or mid-dead-time: aborts immediately to reset state; pending config is discarded.

Test Plan:
- Reset check: hold ARESET 5 cycles, release -> all outputs 0, update_pending 0; outputs stay 0 with no cfg_wr.
- Basic PWM: cfg_wr presc=0 period=9 duty_l=3 duty_r=10 enable=2'b11 dir=2'b11 ->
  - pwm_en[0] high 3 of every 10 cycles; pwm_en[1] constantly high.
  - in_l=in_r=2'b10; period_tick every 10 cycles.
- Mid-period update: with the basic config running, cfg_wr duty_l=7 at cnt=4 ->
  - update_pending=1 until wrap; current period still 3-high; next period 7-high.
  - update_pending returns to 0.
- Coincident write: cfg_wr duty_l=5 exactly on a wrap cycle, while a pending duty_l=7 is queued -> that period uses 7, update_pending stays 1, following period uses 5.
- Reversal: dir=2'b10 applied at wrap ->
  - in_l=2'b00, pwm_en[0]=0 for 16 cycles, then in_l=2'b01 with PWM resumed.
  - Right channel unaffected.
- Prescale and abort:
  - presc=3 period=4 -> period_tick every 20 ACLK.
  - ARESET asserted mid-period -> next cycle all outputs 0 and update_pending 0.
